lsu_sequencer: RTL and testbench
================================

Name: lsu_sequencer

Overview:
- Multi-cycle load/store sequencer between the execute stage and a single-port data memory bus.
- Accepts one access per request using the decoder's MemRw and ldU (funct3) fields.
- Drives a req/ack bus with byte enables, aligns and extends load data, and holds the core busy until the access retires.
- Flags misaligned or illegal accesses and bus timeouts instead of issuing them.

Parameters:
- XLEN, 32, data/address width (only 32 supported)
- TIMEOUT, 16, max cycles mem_req may wait for mem_ack before a fault (>=1)
- CNT_W, 5, width of timeout counter (must hold TIMEOUT)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  access request from execute; sampled only in IDLE
- mem_rw  in  1  1=store, 0=load (decoder MemRw)
- ld_u  in  3  funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW
- addr  in  32  byte address (ALU result)
- wdata  in  32  store data (rs2), low bytes significant
- busy  out  1  high while an access is in flight; core stalls on it
- done  out  1  one-cycle pulse, access retired OK
- rdata  out  32  extended load result; valid with done, held until next done
- fault  out  1  one-cycle pulse, access rejected or timed out
- fault_cause  out  2  01 misaligned, 10 illegal funct3, 11 timeout; held until next fault
- mem_req  out  1  bus request
- mem_we  out  1  1=write
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-shifted store data
- mem_ack  in  1  bus completes access on the rising edge where mem_req&mem_ack
- mem_rdata  in  32  read word, valid in ack cycle

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, fault, mem_req, mem_we = 0; mem_addr, mem_be, mem_wdata, rdata = 0; fault_cause = 00; counter = 0.
- States: IDLE, CHECK, REQ, RESP.
- IDLE: on start, register mem_rw, ld_u, addr, wdata; go to CHECK; busy=1 from next cycle. start in any other state is ignored.
- CHECK (1 cycle): evaluate in priority order:
  - illegal funct3 (load 011/110/111; store with ld_u[2]=1 or 011) -> fault, cause 10, to IDLE;
  - else halfword with addr[0]=1, or word with addr[1:0]!=0 -> fault, cause 01, to IDLE;
  - else drive bus fields, set mem_req=1, clear counter, go to REQ.
  - A faulting access never asserts mem_req.
- Byte enables: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
- Store data: byte replicated into all 4 lanes; half replicated into both halves; word as-is.
- REQ: mem_req and all bus fields held stable until ack.
  - On mem_req&mem_ack at an edge: drop mem_req; for a load, capture the lane-selected, extended mem_rdata into rdata; go to RESP.
  - Extension: LB/LH sign-extend; LBU/LHU zero-extend.
  - Otherwise increment counter. When counter reaches TIMEOUT-1 without ack: drop mem_req, fault with cause 11, to IDLE.
  - An ack on that same edge wins over timeout.
- RESP: done=1 for one cycle; busy=0 in the same cycle; next state IDLE.
  - Best-case latency: start edge -> CHECK -> REQ (ack same cycle) -> done, i.e. done high 3 cycles after start is sampled.
- busy = (state != IDLE) & ~(RESP) and also drops in the fault cycle. done and fault are never high together.
- Reset mid-access: everything returns to reset values immediately; mem_req drops asynchronously; no done or fault pulse; a stale ack after reset is ignored in IDLE.
- mem_ack outside REQ is ignored.

Test Plan:
- LW addr=0x0000_1004, mem_rdata=0xDEAD_BEEF, ack in the first REQ cycle:
  - mem_addr=0x1004, mem_be=1111, mem_we=0;
  - done 3 cycles after start; rdata=0xDEADBEEF.
- LB addr=0x0000_2003, mem_rdata=0x80FF_0000, ack after 4 wait cycles:
  - mem_be=1000; rdata=0xFFFF_FF80; busy high throughout.
  - The same access as LBU gives rdata=0x0000_0080.
- SH addr=0x0000_3002, wdata=0x1234_ABCD:
  - mem_we=1, mem_be=1100, mem_wdata=0xABCD_ABCD; done after ack; rdata unchanged.
- Faulting accesses, both with mem_req never asserted:
  - LW addr=0x0000_4002 -> fault, cause 01, in the cycle after CHECK.
  - Load with ld_u=011 -> fault, cause 10.
- Timeout: TIMEOUT=16, ack never asserted -> mem_req high exactly 16 cycles, then fault with cause 11, busy=0.
  - A following start is accepted normally.
- Reset mid-access: rst_n low during REQ -> mem_req=0 immediately, no done/fault; an ack held high after reset release produces no activity.

Source files
------------

// File: rtl/lsu_sequencer.sv
// Multi-cycle load/store sequencer: checks, issues and retires one data-memory
// access at a time over a req/ack bus, aligning and extending load data.
module lsu_sequencer #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            mem_rw,
    input  logic [2:0]      ld_u,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] rdata,
    output logic            fault,
    output logic [1:0]      fault_cause,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, CHECK, REQ, RESP} state_t;

    state_t            state, state_nxt;
    logic              rw_q;
    logic [2:0]        f3_q;
    logic [XLEN-1:0]   addr_q, wdata_q;
    logic [CNT_W-1:0]  cnt;

    logic              illegal, misaligned, acked, timed_out;
    logic [3:0]        be_c;
    logic [XLEN-1:0]   wdata_c, lane, load_c;

    // Access legality, decided from the registered request.
    always_comb begin
        if (rw_q)
            illegal = f3_q[2] | (f3_q[1:0] == 2'b11);
        else
            illegal = (f3_q == 3'b011) | (f3_q[2:1] == 2'b11);
        misaligned = ((f3_q[1:0] == 2'b01) & addr_q[0]) |
                     ((f3_q[1:0] == 2'b10) & (addr_q[1:0] != 2'b00));
        acked      = (state == REQ) & mem_ack;
        timed_out  = (state == REQ) & ~mem_ack & (cnt == CNT_W'(TIMEOUT - 1));
    end

    always_comb begin
        be_c    = 4'b1111;
        wdata_c = wdata_q;
        case (f3_q[1:0])
            2'b00: begin
                be_c    = 4'b0001 << addr_q[1:0];
                wdata_c = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be_c    = 4'b0011 << addr_q[1:0];
                wdata_c = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        lane   = mem_rdata >> {addr_q[1:0], 3'b000};
        load_c = mem_rdata;
        case (f3_q)
            3'b000:  load_c = {{24{lane[7]}}, lane[7:0]};
            3'b100:  load_c = {24'h0, lane[7:0]};
            3'b001:  load_c = {{16{lane[15]}}, lane[15:0]};
            3'b101:  load_c = {16'h0, lane[15:0]};
            default: load_c = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = CHECK;
            CHECK: state_nxt = (illegal | misaligned) ? IDLE : REQ;
            REQ: begin
                if (acked)
                    state_nxt = RESP;
                else if (timed_out)
                    state_nxt = IDLE;
            end
            RESP:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state == CHECK) | (state == REQ);
        done    = (state == RESP);
        mem_req = (state == REQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rw_q        <= 1'b0;
            f3_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt         <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_be      <= '0;
            mem_wdata   <= '0;
            rdata       <= '0;
            fault       <= 1'b0;
            fault_cause <= 2'b00;
        end else begin
            fault <= 1'b0;
            if ((state == IDLE) && start) begin
                rw_q    <= mem_rw;
                f3_q    <= ld_u;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (state == CHECK) begin
                cnt <= '0;
                if (illegal) begin
                    fault       <= 1'b1;
                    fault_cause <= 2'b10;
                end else if (misaligned) begin
                    fault       <= 1'b1;
                    fault_cause <= 2'b01;
                end else begin
                    mem_we    <= rw_q;
                    mem_addr  <= {addr_q[XLEN-1:2], 2'b00};
                    mem_be    <= be_c;
                    mem_wdata <= wdata_c;
                end
            end
            // An ack on the final wait cycle takes precedence over the timeout.
            if (acked) begin
                if (!rw_q)
                    rdata <= load_c;
            end else if (timed_out) begin
                fault       <= 1'b1;
                fault_cause <= 2'b11;
            end else if (state == REQ) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lsu_sequencer.sv
// Randomized self-checking bench for lsu_sequencer against a transaction-level
// model of access legality, lane placement, extension and bus timing.
module tb_lsu_sequencer;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n, start, mem_rw, mem_ack;
    logic [2:0]  ld_u;
    logic [31:0] addr, wdata, mem_rdata;
    logic        busy, done, fault, mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [1:0]  fault_cause;
    logic [3:0]  mem_be;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] exp_rdata = '0;
    logic [1:0]  exp_cause = 2'b00;

    always #5 clk = ~clk;

    lsu_sequencer #(.XLEN(32), .TIMEOUT(TO), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mem_rw(mem_rw), .ld_u(ld_u),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
        .fault(fault), .fault_cause(fault_cause), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    initial begin
        #2ms;
        $display("FAIL watchdog: got no finish, expected finish within 2ms");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] word);
        logic [31:0] b, h;
        b = (word / (32'd1 << (8 * off))) % 32'd256;
        h = (word / (32'd1 << (8 * off))) % 32'd65536;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd5:    return h;
            default: return word;
        endcase
    endfunction

    // ack_delay = number of wait cycles before ack; >= TO means never acked.
    task automatic access(input logic rw, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] word, input int ack_delay);
        bit ill, mis;
        logic [1:0] off;
        logic [3:0] ebe;
        logic [31:0] ewd;
        int n;
        off = a[1:0];
        ill = rw ? (f3 >= 3'd3) : (f3 == 3'd3 || f3 >= 3'd6);
        mis = !ill && (((f3 % 4) == 1 && (a % 2) != 0) || ((f3 % 4) == 2 && (a % 4) != 0));
        case (f3 % 4)
            0:       begin ebe = 4'd1 << off; ewd = {24'h0, wd[7:0]} * 32'h0101_0101; end
            1:       begin ebe = 4'd3 << off; ewd = {16'h0, wd[15:0]} * 32'h0001_0001; end
            default: begin ebe = 4'hF; ewd = wd; end
        endcase

        start = 1'b1; mem_rw = rw; ld_u = f3; addr = a; wdata = wd;
        @(negedge clk);
        start = 1'b0; mem_rw = $urandom; ld_u = $urandom; addr = $urandom; wdata = $urandom;
        check("check_busy", busy, 1);
        check("check_noreq", mem_req, 0);
        @(negedge clk);
        if (ill || mis) begin
            exp_cause = ill ? 2'b10 : 2'b01;
            check("flt_pulse", fault, 1);
            check("flt_cause", fault_cause, exp_cause);
            check("flt_busy", busy, 0);
            check("flt_req", mem_req, 0);
            check("flt_done", done, 0);
        end else begin
            check("bus_we", mem_we, rw);
            check("bus_addr", mem_addr, a & 32'hFFFF_FFFC);
            check("bus_be", mem_be, ebe);
            if (rw) check("bus_wdata", mem_wdata, ewd);
            n = 0;
            while (1) begin
                check("req_high", mem_req, 1);
                check("req_busy", busy, 1);
                check("req_be", mem_be, ebe);
                n++;
                if (n - 1 == ack_delay) begin mem_ack = 1'b1; mem_rdata = word; end
                @(negedge clk);
                mem_ack = 1'b0; mem_rdata = $urandom;
                if (n - 1 == ack_delay) begin
                    if (!rw) exp_rdata = model_load(f3, off, word);
                    check("ret_done", done, 1);
                    check("ret_busy", busy, 0);
                    check("ret_fault", fault, 0);
                    check("ret_req", mem_req, 0);
                    check("ret_rdata", rdata, exp_rdata);
                    break;
                end
                if (n >= TO) begin
                    exp_cause = 2'b11;
                    check("to_req", mem_req, 0);
                    check("to_fault", fault, 1);
                    check("to_cause", fault_cause, exp_cause);
                    check("to_busy", busy, 0);
                    check("to_done", done, 0);
                    break;
                end
            end
        end
        @(negedge clk);
        check("after_done", done, 0);
        check("after_fault", fault, 0);
        check("after_busy", busy, 0);
        check("after_cause", fault_cause, exp_cause);
        check("after_rdata", rdata, exp_rdata);
    endtask

    initial begin
        logic [2:0] f3;
        logic [31:0] a;
        rst_n = 1'b0; start = 1'b0; mem_rw = 1'b0; ld_u = '0; addr = '0; wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fault", fault, 0);
        check("rst_req", mem_req, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_be", mem_be, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_rdata", rdata, 0);
        check("rst_cause", fault_cause, 0);
        rst_n = 1'b1;
        @(negedge clk);

        access(1'b0, 3'd2, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0);
        check("lw_rdata", rdata, 32'hDEAD_BEEF);
        access(1'b0, 3'd0, 32'h0000_2003, 32'h0, 32'h80FF_0000, 4);
        check("lb_rdata", rdata, 32'hFFFF_FF80);
        access(1'b0, 3'd4, 32'h0000_2003, 32'h0, 32'h80FF_0000, 4);
        check("lbu_rdata", rdata, 32'h0000_0080);
        access(1'b1, 3'd1, 32'h0000_3002, 32'h1234_ABCD, 32'h0, 2);
        check("sh_rdata", rdata, 32'h0000_0080);
        access(1'b0, 3'd2, 32'h0000_4002, 32'h0, 32'h0, 0);
        access(1'b0, 3'd3, 32'h0000_4000, 32'h0, 32'h0, 0);
        access(1'b0, 3'd2, 32'h0000_5000, 32'h0, 32'h0, TO + 5);
        access(1'b0, 3'd5, 32'h0000_5002, 32'h0, 32'hBEEF_1234, 0);
        access(1'b0, 3'd1, 32'h0000_6002, 32'h0, 32'h9ABC_0000, TO - 1);

        for (int i = 0; i < 150; i++) begin
            f3 = 3'($urandom);
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = (f3[1:0] == 2'b10) ? 2'b00 : a[1:0] & {1'b1, ~f3[0]};
            access(1'($urandom), f3, a, $urandom, $urandom, int'($urandom_range(0, TO + 4)));
        end

        access(1'b0, 3'd2, 32'h0000_7000, 32'h0, 32'h0, TO + 5);
        @(negedge clk);
        start = 1'b1; mem_rw = 1'b0; ld_u = 3'd2; addr = 32'h0000_8000;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_req_before", mem_req, 1);
        rst_n = 1'b0;
        #1;
        check("mid_req", mem_req, 0);
        check("mid_busy", busy, 0);
        check("mid_done", done, 0);
        check("mid_fault", fault, 0);
        check("mid_rdata", rdata, 0);
        check("mid_cause", fault_cause, 0);
        exp_rdata = '0;
        exp_cause = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        repeat (3) begin
            @(negedge clk);
            check("stale_req", mem_req, 0);
            check("stale_busy", busy, 0);
            check("stale_done", done, 0);
            check("stale_fault", fault, 0);
            check("stale_rdata", rdata, 0);
        end
        mem_ack = 1'b0;
        access(1'b0, 3'd0, 32'h0000_9001, 32'h0, 32'h0000_7F00, 1);
        check("post_rst_rdata", rdata, 32'h0000_007F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
